c432_key_loader: RTL
====================

# c432_key_loader

Sequential key-management controller for the 24-bit logic-locked c432 netlist. It fetches the locking key from an external key store over a valid/ready byte interface and verifies an XOR checksum. Only after a successful check does it drive the netlist's `keyinput0..keyinput23`. Until then it forces the seven primary outputs to zero, and it supports re-keying, bounded retry on checksum failure, and immediate zeroization.

## Interface
Parameters:
- `KEY_W`, 24: key width; must be a multiple of `BEAT_W`.
- `BEAT_W`, 8: key-store beat width.
- `MAX_RETRY`, 1: reloads permitted after a checksum failure before `err` is raised.

Ports:
- `CK`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a key load or re-key, sampled each edge.
- `zeroize`  in  1  clear the key immediately; highest priority.
- `kd_valid`  in  1  key-store beat valid.
- `kd_data`  in  `BEAT_W`  key-store beat payload.
- `kd_ready`  out  1  controller accepts a beat.
- `key_out`  out  `KEY_W`  drives `keyinput[i]` = `key_out[i]`.
- `key_valid`  out  1  `key_out` holds a verified key.
- `busy`  out  1  a load or check is in progress.
- `err`  out  1  sticky checksum-failure flag.
- `ckt_in`  in  7  raw netlist outputs {G432,G431,G430,G421,G370,G329,G223}, with bit 0 = G223.
- `ckt_out`  out  7  gated outputs: `ckt_in & {7{key_valid}}`. This is the only combinational path.

## Operation
- NB = `KEY_W/BEAT_W` data beats, followed by one checksum beat. The checksum is the XOR of all NB data beats.
- Beat order is little-endian: beat k fills shadow bits [k*BEAT_W +: BEAT_W].
- State machine:
  - IDLE: `start` → LOAD.
  - LOAD: `kd_ready`=1. A beat transfers when `kd_valid & kd_ready`. After NB data beats plus the checksum beat → CHECK.
  - CHECK, one cycle:
    - Match → ARMED: shadow copied to `key_out`, `key_valid`=1, retry count cleared.
    - Mismatch with retry count < `MAX_RETRY` → LOAD: count incremented, beat index reset to 0.
    - Mismatch otherwise → ERR.
  - ARMED: `start` → LOAD (re-key).
  - ERR: `err`=1. `start` is ignored. Exits only via `rst` or `zeroize`, both of which go to IDLE.
- Entering LOAD from any state clears `key_out`, `key_valid` and the shadow register in the same edge.
- `start` is ignored in LOAD and CHECK.
- `zeroize` from any state → IDLE. It clears `key_out`, `key_valid`, the shadow register, the beat index and the retry count. A beat in flight that cycle is discarded.
- `err` is cleared only by `rst`; `zeroize` leaves it unchanged.
- `zeroize` and `start` in the same cycle: `zeroize` wins and `start` is dropped.
- `busy` = 1 in LOAD and CHECK, 0 otherwise.
- Beats offered outside LOAD are not accepted (`kd_ready`=0) and leave no side effect.

## Timing
- Reset values (asynchronous, visible immediately):
  - state IDLE.
  - `key_out`=0, `key_valid`=0, `kd_ready`=0, `busy`=0, `err`=0.
  - `ckt_out`=0 as a consequence of `key_valid`=0.
- `kd_ready` and `busy` are registered state decodes. `kd_ready` first rises in the cycle after the edge that samples `start`.
- Latency with `kd_valid` held high (24-bit key):
  - `start` sampled at edge 0.
  - Beats accepted at edges 1, 2, 3 and 4 (edge 4 = checksum).
  - CHECK during cycle 5; `key_valid`=1 after edge 5.
  - Total: 5 cycles from `start`.
- Stalls on `kd_valid` extend LOAD without limit; there is no timeout.
- A failed check costs one cycle; the next LOAD begins after the CHECK edge.
- `key_out` changes only at the CHECK→ARMED edge or on clear. It never shows a partial key.
- `rst` asserted mid-LOAD returns to IDLE asynchronously; a beat in that cycle is not accepted.

## Test plan
- Happy path: after reset, check all outputs are 0. Pulse `start`, then stream F0, C3, A5, 96 back-to-back. Require `key_out`=0xA5C3F0 and `key_valid`=1 five cycles after `start`, and `ckt_out`=`ckt_in` from then on.
- Retry: stream F0, C3, A5, 00 (bad), then F0, C3, A5, 96. Require one return to LOAD, final `key_out`=0xA5C3F0, `err`=0.
- Error: two bad sequences with `MAX_RETRY`=1. Require `err`=1, `key_valid`=0, `ckt_out`=0. A later `start` is ignored; `zeroize` → IDLE with `err` still 1; `rst` clears `err`.
- Stalls and back-pressure:
  - Toggle `kd_valid` randomly during the load: the key must be correct.
  - Offer beats in IDLE: `kd_ready`=0 and no state change.
- Zeroize:
  - Assert `zeroize` after 2 beats: `kd_ready`=0 next cycle and key cleared. A fresh `start` needs all 4 beats.
  - Assert `zeroize` and `start` together in ARMED → IDLE.
- Re-key: from ARMED with 0xA5C3F0, `start` then stream 01, 02, 03, 00. Require `key_valid`=0 throughout LOAD, then `key_out`=0x030201.

Source files
------------

// File: rtl/c432_key_loader_if.sv
// ---------------------------------------------------------------------------
// c432_key_loader_if
// Valid/ready byte bus between the external key store (master) and the key
// loader (slave).
//   kd_valid  master -> slave  beat on kd_data is valid
//   kd_data   master -> slave  beat payload, BEAT_W bits
//   kd_ready  slave  -> master loader accepts a beat this cycle
// ---------------------------------------------------------------------------
interface c432_key_loader_if #(
  parameter int BEAT_W = 8
) ();
  logic              kd_valid;
  logic [BEAT_W-1:0] kd_data;
  logic              kd_ready;

  modport master (
    output kd_valid,
    output kd_data,
    input  kd_ready
  );

  modport slave (
    input  kd_valid,
    input  kd_data,
    output kd_ready
  );
endinterface

// File: rtl/c432_key_loader.sv
// ---------------------------------------------------------------------------
// c432_key_loader
// Key-management controller for the 24-bit logic-locked c432 netlist. Fetches
// NB = KEY_W/BEAT_W little-endian key beats plus one XOR checksum beat from a
// key store, verifies the checksum and only then drives the netlist key
// inputs. Until a verified key is present the netlist outputs are forced to 0.
// Ports:
//   CK        clock, rising edge
//   rst       asynchronous active-high reset
//   start     request a key load / re-key
//   zeroize   clear key immediately, highest priority
//   kd        key-store valid/ready beat bus (slave side)
//   key_out   key driven onto keyinput[KEY_W-1:0]
//   key_valid key_out holds a verified key
//   busy      load or check in progress
//   err       sticky checksum-failure flag (cleared only by rst)
//   ckt_in    raw netlist outputs {G432,G431,G430,G421,G370,G329,G223}
//   ckt_out   ckt_in gated by key_valid (only combinational path)
// ---------------------------------------------------------------------------
module c432_key_loader #(
  parameter int KEY_W     = 24,
  parameter int BEAT_W    = 8,
  parameter int MAX_RETRY = 1
) (
  input  logic                 CK,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 zeroize,
  c432_key_loader_if.slave     kd,
  output logic [KEY_W-1:0]     key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 err,
  input  logic [6:0]           ckt_in,
  output logic [6:0]           ckt_out
);

  localparam int NB      = KEY_W / BEAT_W;
  // Beat index runs 0..NB; index NB is the checksum beat.
  localparam int IDX_W   = $clog2(NB + 1);
  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ARMED = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [RETRY_W-1:0]  retry_q,     retry_d;
  logic [KEY_W-1:0]    shadow_q,    shadow_d;
  logic [BEAT_W-1:0]   chk_q,       chk_d;
  logic [KEY_W-1:0]    key_q,       key_d;
  logic                key_valid_q, key_valid_d;
  logic                err_q,       err_d;
  logic                kd_ready_q;
  logic                busy_q;

  // XOR of all data beats held in a key-sized word.
  function automatic logic [BEAT_W-1:0] xor_beats(input logic [KEY_W-1:0] k);
    logic [BEAT_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < NB; b++) begin
      acc = acc ^ k[b*BEAT_W +: BEAT_W];
    end
    return acc;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    shadow_d    = shadow_q;
    chk_d       = chk_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;

    if (zeroize) begin
      // Any beat in flight this cycle is dropped along with the key material.
      state_d     = S_IDLE;
      idx_d       = '0;
      retry_d     = '0;
      shadow_d    = '0;
      key_d       = '0;
      key_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d     = S_LOAD;
            idx_d       = '0;
            shadow_d    = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
          end
        end

        S_LOAD: begin
          // kd_ready is 1 throughout LOAD, so kd_valid alone marks a transfer.
          if (kd.kd_valid) begin
            for (int k = 0; k < NB; k++) begin
              if (idx_q == IDX_W'(k)) begin
                shadow_d[k*BEAT_W +: BEAT_W] = kd.kd_data;
              end
            end
            if (idx_q == IDX_W'(NB)) begin
              chk_d   = kd.kd_data;
              state_d = S_CHECK;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end

        S_CHECK: begin
          if (xor_beats(shadow_q) == chk_q) begin
            state_d     = S_ARMED;
            key_d       = shadow_q;
            key_valid_d = 1'b1;
            retry_d     = '0;
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            state_d  = S_LOAD;
            retry_d  = retry_q + RETRY_W'(1);
            idx_d    = '0;
            shadow_d = '0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end

        S_ARMED: begin
          // Re-key: the old key is withdrawn as soon as loading starts.
          if (start) begin
            state_d     = S_LOAD;
            idx_d       = '0;
            shadow_d    = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
          end
        end

        S_ERR: begin
          // Locked out; only zeroize (above) or rst leave this state.
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CK or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      shadow_q    <= '0;
      chk_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      kd_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      shadow_q    <= shadow_d;
      chk_q       <= chk_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      // Decoded from the next state so both are plain flop outputs.
      kd_ready_q  <= (state_d == S_LOAD);
      busy_q      <= (state_d == S_LOAD) || (state_d == S_CHECK);
    end
  end

  assign kd.kd_ready = kd_ready_q;
  assign key_out     = key_q;
  assign key_valid   = key_valid_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign ckt_out     = ckt_in & {7{key_valid_q}};

endmodule
